mux4_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one Multiplexer4Bit data path among four requesters.
- Drives the mux 2-bit select and a one-hot grant.
- Bounds ownership with a hold timeout so that no requester starves the others.
- Sits between the requester blocks and the ALU operand mux, and qualifies the mux output with valid.

---
 rtl/mux_arb_pkg.sv | 35 +++
 rtl/rr_pick4.sv | 33 +++
 rtl/mux4_rr_arbiter.sv | 131 +++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg
// Shared definitions for the four-way round-robin arbiter:
//   - arbState_t : arbiter FSM states (IDLE, GRANT, GAP)
//   - NUM_REQ    : number of requesters sharing the mux
//   - SEL_A..D   : Multiplexer4Bit select codes
//   - ownerToSel : maps an owner index to its mux select code
package mux_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } arbState_t;

   localparam int NUM_REQ = 4;

   // The mux uses selectorBits[1] to pick within a pair and selectorBits[0]
   // to pick between pairs, so the select code is the owner index bit-swapped.
   localparam logic [1:0] SEL_A = 2'b00;
   localparam logic [1:0] SEL_B = 2'b10;
   localparam logic [1:0] SEL_C = 2'b01;
   localparam logic [1:0] SEL_D = 2'b11;

   function automatic logic [1:0] ownerToSel(input logic [1:0] ownerIdx);
      logic [1:0] code;
      case (ownerIdx)
         2'd0:    code = SEL_A;
         2'd1:    code = SEL_B;
         2'd2:    code = SEL_C;
         default: code = SEL_D;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/rr_pick4.sv
// rr_pick4
// Combinational rotate-priority encoder. Scans req starting at ptr and
// wrapping around, and reports the first requester found.
// Ports:
//   req    in  [3:0] request vector
//   ptr    in  [1:0] index with the highest priority
//   winner out [1:0] first set bit at or after ptr (ptr when none set)
//   any    out       at least one request is set
module rr_pick4
   import mux_arb_pkg::*;
(
   input  logic [3:0] req,
   input  logic [1:0] ptr,
   output logic [1:0] winner,
   output logic       any
);

   // Walk from the farthest position back towards ptr so that the nearest
   // set request is the last assignment and therefore wins.
   always_comb begin
      logic [1:0] idx;
      winner = ptr;
      any    = |req;
      idx    = ptr;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = ptr + 2'(k);
         if (req[idx]) begin
            winner = idx;
         end
      end
   end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter
// Round-robin arbiter sharing one Multiplexer4Bit among four requesters.
// Ownership is bounded by a hold timeout while others are waiting, and
// every release is followed by one dead cycle before the select may move.
// Parameters:
//   HOLD_MAX  max consecutive grant cycles while others wait (1..255)
//   CNT_W     hold counter width, 2**CNT_W > HOLD_MAX
// Ports:
//   clk      in       rising-edge clock
//   rst      in       synchronous active-high reset
//   req      in  [3:0] level requests
//   grant    out [3:0] registered one-hot grant, zero when no owner
//   owner    out [1:0] current/last owner index
//   sel      out [1:0] mux select derived from owner
//   valid    out      a grant is active, mux output meaningful
//   preempt  out      one-cycle pulse on a timeout release
module mux4_rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter int HOLD_MAX = 8,
   parameter int CNT_W    = 8
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   output logic [3:0] grant,
   output logic [1:0] owner,
   output logic [1:0] sel,
   output logic       valid,
   output logic       preempt
);

   if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : gHoldRangeCheck
      $error("mux4_rr_arbiter: HOLD_MAX must be in 1..255");
   end
   if ((2 ** CNT_W) <= HOLD_MAX) begin : gCntWidthCheck
      $error("mux4_rr_arbiter: CNT_W too narrow for HOLD_MAX");
   end

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

   arbState_t        state, nextState;
   logic [1:0]       ptr, nextPtr;
   logic [CNT_W-1:0] holdCnt, nextHoldCnt;
   logic [3:0]       nextGrant;
   logic [1:0]       nextOwner, nextSel;
   logic             nextPreempt;
   logic [1:0]       pickWinner;
   logic             pickAny;
   logic             othersReq;

   rr_pick4 uPick (
      .req    (req),
      .ptr    (ptr),
      .winner (pickWinner),
      .any    (pickAny)
   );

   assign othersReq = |(req & ~(4'b0001 << owner));
   assign valid     = (state == GRANT);

   // State, pointer, counter and output registers. Reset clears everything
   // on the same edge, even in the middle of a grant.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         ptr     <= 2'd0;
         holdCnt <= '0;
         grant   <= 4'b0000;
         owner   <= 2'd0;
         sel     <= SEL_A;
         preempt <= 1'b0;
      end else begin
         state   <= nextState;
         ptr     <= nextPtr;
         holdCnt <= nextHoldCnt;
         grant   <= nextGrant;
         owner   <= nextOwner;
         sel     <= nextSel;
         preempt <= nextPreempt;
      end
   end

   // Next-state logic. owner and sel only move when a new grant is issued,
   // so the select never changes during the dead GAP cycle. A normal release
   // (owner dropped req) takes precedence over a coincident timeout.
   always_comb begin
      nextState   = state;
      nextPtr     = ptr;
      nextHoldCnt = holdCnt;
      nextGrant   = grant;
      nextOwner   = owner;
      nextSel     = sel;
      nextPreempt = 1'b0;

      case (state)
         IDLE, GAP: begin
            nextGrant = 4'b0000;
            if (pickAny) begin
               nextState   = GRANT;
               nextGrant   = 4'b0001 << pickWinner;
               nextOwner   = pickWinner;
               nextSel     = ownerToSel(pickWinner);
               nextHoldCnt = '0;
            end else begin
               nextState = IDLE;
            end
         end
         GRANT: begin
            if (!req[owner]) begin
               nextState = GAP;
               nextGrant = 4'b0000;
               nextPtr   = owner + 2'd1;
            end else if (holdCnt == HOLD_LAST && othersReq) begin
               nextState   = GAP;
               nextGrant   = 4'b0000;
               nextPtr     = owner + 2'd1;
               nextPreempt = 1'b1;
            end else if (holdCnt != HOLD_LAST) begin
               nextHoldCnt = holdCnt + 1'b1;
            end
         end
         default: begin
            nextState = IDLE;
            nextGrant = 4'b0000;
         end
      endcase
   end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter
// Self-checking bench for mux4_rr_arbiter (HOLD_MAX=4). A behavioural model
// tracks owner, cycles held and the round-robin pointer, and is compared
// against the DUT every cycle; directed sequences add literal expectations.
module tb_mux4_rr_arbiter;

   localparam int HOLD = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req;
   logic [3:0] grant;
   logic [1:0] owner;
   logic [1:0] sel;
   logic       valid;
   logic       preempt;

   int checks   = 0;
   int failures = 0;

   mux4_rr_arbiter #(.HOLD_MAX(HOLD), .CNT_W(8)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .grant   (grant),
      .owner   (owner),
      .sel     (sel),
      .valid   (valid),
      .preempt (preempt)
   );

   always #5 clk = ~clk;

   // Model state: whether someone owns the mux, who, for how many completed
   // cycles, where the rotation starts next, and the preempt pulse.
   bit         mReady = 0;
   bit         mBusy;
   int         mOwner;
   int         mHeld;
   int         mPtr;
   bit         mPre;
   logic [1:0] selTable [4];
   logic [3:0] expGrant;
   logic [1:0] expSel;

   initial begin
      selTable = '{2'b00, 2'b10, 2'b01, 2'b11};
   end

   task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   function automatic int pickNext(input logic [3:0] r, input int p);
      for (int k = 0; k < 4; k++) begin
         if (r[(p + k) % 4]) return (p + k) % 4;
      end
      return -1;
   endfunction

   // Model update on each rising edge from the inputs present at that edge.
   // Releasing simply drops ownership; the following edge arbitrates again,
   // which yields the single dead cycle.
   always @(posedge clk) begin
      int w;
      logic [3:0] others;
      if (rst) begin
         mReady = 1;
         mBusy  = 0;
         mOwner = 0;
         mHeld  = 0;
         mPtr   = 0;
         mPre   = 0;
      end else if (mReady) begin
         mPre = 0;
         if (mBusy) begin
            mHeld++;
            others = req & ~(4'(1 << mOwner));
            if (!req[mOwner]) begin
               mBusy = 0;
               mPtr  = (mOwner + 1) % 4;
            end else if (mHeld >= HOLD && others != 4'b0000) begin
               mBusy = 0;
               mPtr  = (mOwner + 1) % 4;
               mPre  = 1;
            end
         end else begin
            w = pickNext(req, mPtr);
            if (w >= 0) begin
               mBusy  = 1;
               mOwner = w;
               mHeld  = 0;
            end
         end
      end
   end

   // Compare process: every falling edge once the model has seen reset.
   always @(negedge clk) begin
      if (mReady) begin
         expGrant = mBusy ? 4'(1 << mOwner) : 4'b0000;
         expSel   = selTable[mOwner];
         checkOutput("model.grant",   8'(grant),   8'(expGrant));
         checkOutput("model.owner",   8'(owner),   8'(mOwner));
         checkOutput("model.sel",     8'(sel),     8'(expSel));
         checkOutput("model.valid",   8'(valid),   8'(mBusy));
         checkOutput("model.preempt", 8'(preempt), 8'(mPre));
      end
   end

   // Drive rst/req just after a rising edge and let n edges pass; returns
   // 2 time units after the last edge so outputs can be sampled directly.
   task automatic applyStimulus(input logic r, input logic [3:0] q, input int n);
      rst = r;
      req = q;
      repeat (n) @(posedge clk);
      #2;
   endtask

   logic [3:0] toGrant [11];
   logic       toPre   [11];
   logic [3:0] rrOrder [5];

   initial begin
      toGrant = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000,
                  4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0001};
      toPre   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      rrOrder = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      rst = 1'b1;
      req = 4'b1111;

      // Reset held with all requests pending, then first grant.
      applyStimulus(1'b1, 4'b1111, 2);
      checkOutput("reset.grant", 8'(grant), 8'h00);
      checkOutput("reset.valid", 8'(valid), 8'h00);
      checkOutput("reset.sel",   8'(sel),   8'h00);
      applyStimulus(1'b0, 4'b1111, 1);
      checkOutput("first.grant", 8'(grant), 8'h01);
      checkOutput("first.owner", 8'(owner), 8'h00);
      applyStimulus(1'b0, 4'b0000, 2);

      // Select mapping for B, C, D with a dead cycle between grants.
      applyStimulus(1'b0, 4'b0010, 1);
      checkOutput("selB.sel", 8'(sel), 8'h02);
      applyStimulus(1'b0, 4'b0010, 2);
      checkOutput("selB.valid3", 8'(valid), 8'h01);
      applyStimulus(1'b0, 4'b0100, 1);
      checkOutput("gapBC.valid", 8'(valid), 8'h00);
      checkOutput("gapBC.selHeld", 8'(sel), 8'h02);
      applyStimulus(1'b0, 4'b0100, 1);
      checkOutput("selC.sel", 8'(sel), 8'h01);
      applyStimulus(1'b0, 4'b0100, 2);
      applyStimulus(1'b0, 4'b1000, 2);
      checkOutput("selD.sel", 8'(sel), 8'h03);
      checkOutput("selD.grant", 8'(grant), 8'h08);
      applyStimulus(1'b0, 4'b1000, 2);
      applyStimulus(1'b0, 4'b0000, 2);

      // Timeout rotation between requesters 0 and 1.
      for (int i = 0; i < 11; i++) begin
         applyStimulus(1'b0, 4'b0011, 1);
         checkOutput($sformatf("timeout.grant[%0d]", i), 8'(grant), 8'(toGrant[i]));
         checkOutput($sformatf("timeout.preempt[%0d]", i), 8'(preempt), 8'(toPre[i]));
      end
      applyStimulus(1'b0, 4'b0000, 2);

      // Lone hog: no one else waiting, so no timeout.
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b0, 4'b0100, 1);
         checkOutput($sformatf("hog.grant[%0d]", i), 8'(grant), 8'h04);
         checkOutput($sformatf("hog.preempt[%0d]", i), 8'(preempt), 8'h00);
      end
      applyStimulus(1'b0, 4'b0000, 2);

      // Round-robin fairness from a fresh pointer.
      applyStimulus(1'b1, 4'b0000, 1);
      applyStimulus(1'b0, 4'b1111, 1);
      checkOutput("rr.grant[0]", 8'(grant), 8'(rrOrder[0]));
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 4'b1111, 1);
         checkOutput($sformatf("rr.hold[%0d]", i), 8'(grant), 8'(rrOrder[i]));
         applyStimulus(1'b0, 4'b1111 & ~rrOrder[i], 1);
         checkOutput($sformatf("rr.gap[%0d]", i), 8'(grant), 8'h00);
         applyStimulus(1'b0, 4'b1111, 1);
         checkOutput($sformatf("rr.grant[%0d]", i + 1), 8'(grant), 8'(rrOrder[i + 1]));
      end

      // Mid-grant reset: pointer returns to 0, so 0 beats 3.
      applyStimulus(1'b1, 4'b0000, 1);
      applyStimulus(1'b0, 4'b1000, 1);
      checkOutput("mid.grantD", 8'(grant), 8'h08);
      applyStimulus(1'b1, 4'b1001, 1);
      checkOutput("mid.resetGrant", 8'(grant), 8'h00);
      checkOutput("mid.resetValid", 8'(valid), 8'h00);
      checkOutput("mid.resetOwner", 8'(owner), 8'h00);
      applyStimulus(1'b0, 4'b1001, 1);
      checkOutput("mid.regrant", 8'(grant), 8'h01);
      applyStimulus(1'b0, 4'b0000, 3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
